endereco_playback_seq: RTL and testbench

Parametrised playback address sequencer for the music player. It generates the PCM memory address for the current track, applies short and long forward/backward seeks, and tracks the net seek offset in seconds. It detects end of track from the address bound and, optionally, from a run of zero samples. It sits between the button/debounce front end and the PCM memory, and hands off to the track selector through a `prox_musica` / `load` handshake.

---
 rtl/endereco_playback_seq.sv | 219 +++++++++++++++++++++
 tb/tb_endereco_playback_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endereco_playback_seq.sv
// endereco_playback_seq: PCM playback address sequencer with short/long seeks, net seek-time tracking and end-of-track detection.
// Latency: load/seek/count sampled on a rising clk edge appear on the registered outputs immediately after that edge.
// Backpressure: none; events that lose priority or arrive in a state that ignores them are dropped, never queued.
//
// Optional feature: define EOT_ZERO_DETECT_EN to build the zero-sample-run end-of-track detector.
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   count                  sample strobe, advances endereco by one while playing
//   passa_10s/volta_10s    short forward/backward seek buttons (debounced, act on rising edge)
//   passa_30s/volta_30s    long forward/backward seek buttons (debounced, act on rising edge)
//   load                   one-cycle pulse: jump to track_start and start playing
//   track_start/track_end  inclusive address bounds of the current track
//   current_value          PCM sample read at endereco
//   endereco               current PCM address
//   time_adder             signed net seek offset in seconds (saturating)
//   prox_musica            one-cycle end-of-track pulse to the track selector
//   playing                high while in PLAY
module endereco_playback_seq #(
    parameter int ADDR_W          = 22,
    parameter int SAMPLE_W        = 8,
    parameter int SAMPLES_PER_SEC = 8000,
    parameter int SKIP_SHORT_S    = 10,
    parameter int SKIP_LONG_S     = 30,
    parameter int TIME_W          = 9,
    parameter int ZERO_RUN        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     count,
    input  logic                     passa_10s,
    input  logic                     volta_10s,
    input  logic                     passa_30s,
    input  logic                     volta_30s,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        track_start,
    input  logic [ADDR_W-1:0]        track_end,
    input  logic [SAMPLE_W-1:0]      current_value,
    output logic [ADDR_W-1:0]        endereco,
    output logic signed [TIME_W-1:0] time_adder,
    output logic                     prox_musica,
    output logic                     playing
);

    // Seek distances in samples, one bit wider than the address so bound checks cannot wrap.
    localparam logic [ADDR_W:0] STEP_SHORT = (ADDR_W+1)'(SKIP_SHORT_S * SAMPLES_PER_SEC);
    localparam logic [ADDR_W:0] STEP_LONG  = (ADDR_W+1)'(SKIP_LONG_S * SAMPLES_PER_SEC);

    // Seek time deltas and saturation limits, one bit wider than time_adder.
    localparam logic signed [TIME_W:0] DT_SHORT = (TIME_W+1)'(SKIP_SHORT_S);
    localparam logic signed [TIME_W:0] DT_LONG  = (TIME_W+1)'(SKIP_LONG_S);
    localparam logic signed [TIME_W:0] TA_MAX   = (TIME_W+1)'((1 << (TIME_W-1)) - 1);
    localparam logic signed [TIME_W:0] TA_MIN   = (TIME_W+1)'(-(1 << (TIME_W-1)));

    typedef enum logic [1:0] {
        S_WAIT_LOAD = 2'd0,
        S_PLAY      = 2'd1,
        S_END       = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        endereco_nxt;
    logic signed [TIME_W-1:0] time_adder_nxt;

    // Button history: bit order is seek priority, highest first.
    logic [3:0]               btn_now, btn_prev, btn_rise;

    logic                     seek_vld, seek_fwd;
    logic [ADDR_W:0]          seek_step;
    logic signed [TIME_W:0]   seek_dt;
    logic [ADDR_W:0]          addr_ext, fwd_sum, back_room, back_diff;
    logic                     fwd_ok, back_ok;

    logic                     zero_clr, zero_upd, zero_hit;

    function automatic logic signed [TIME_W-1:0] sat_add(
        input logic signed [TIME_W-1:0] a,
        input logic signed [TIME_W:0]   d
    );
        logic signed [TIME_W:0] s;
        s = $signed({a[TIME_W-1], a}) + d;
        if (s > TA_MAX) begin
            s = TA_MAX;
        end else if (s < TA_MIN) begin
            s = TA_MIN;
        end
        return $signed(s[TIME_W-1:0]);
    endfunction

    assign btn_now  = {passa_30s, volta_30s, passa_10s, volta_10s};
    assign btn_rise = btn_now & ~btn_prev;

    // Pick the single winning seek for this cycle; the others are simply dropped.
    always_comb begin
        seek_vld  = |btn_rise;
        seek_fwd  = 1'b0;
        seek_step = STEP_SHORT;
        seek_dt   = -DT_SHORT;
        if (btn_rise[3]) begin
            seek_fwd  = 1'b1;
            seek_step = STEP_LONG;
            seek_dt   = DT_LONG;
        end else if (btn_rise[2]) begin
            seek_step = STEP_LONG;
            seek_dt   = -DT_LONG;
        end else if (btn_rise[1]) begin
            seek_fwd  = 1'b1;
            seek_dt   = DT_SHORT;
        end
    end

    // endereco never drops below track_start while playing, so back_room is a true distance.
    assign addr_ext  = {1'b0, endereco};
    assign fwd_sum   = addr_ext + seek_step;
    assign fwd_ok    = (fwd_sum <= {1'b0, track_end});
    assign back_room = addr_ext - {1'b0, track_start};
    assign back_ok   = (back_room >= seek_step);
    assign back_diff = addr_ext - seek_step;

`ifdef EOT_ZERO_DETECT_EN
    localparam int ZC_W = $clog2(ZERO_RUN + 1);

    logic [ZC_W-1:0] zero_cnt, zero_cnt_inc;
    logic            sample_zero;

    assign sample_zero  = (current_value == '0);
    assign zero_cnt_inc = zero_cnt + ZC_W'(1);
    assign zero_hit     = sample_zero && (zero_cnt_inc == ZC_W'(ZERO_RUN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_cnt <= '0;
        end else if (zero_clr) begin
            zero_cnt <= '0;
        end else if (zero_upd) begin
            zero_cnt <= sample_zero ? zero_cnt_inc : '0;
        end
    end
`else
    localparam int unused_zero_run = ZERO_RUN;
    logic          unused_zero;

    assign zero_hit    = 1'b0;
    assign unused_zero = ^{current_value, zero_clr, zero_upd};
`endif

    always_comb begin
        state_nxt      = state;
        endereco_nxt   = endereco;
        time_adder_nxt = time_adder;
        zero_clr       = 1'b0;
        zero_upd       = 1'b0;
        case (state)
            S_WAIT_LOAD: begin
                if (load) begin
                    endereco_nxt   = track_start;
                    time_adder_nxt = '0;
                    zero_clr       = 1'b1;
                    state_nxt      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (load) begin
                    endereco_nxt   = track_start;
                    time_adder_nxt = '0;
                    zero_clr       = 1'b1;
                end else if (seek_vld) begin
                    if (seek_fwd) begin
                        if (fwd_ok) begin
                            endereco_nxt   = fwd_sum[ADDR_W-1:0];
                            time_adder_nxt = sat_add(time_adder, seek_dt);
                        end else begin
                            // Seeking past the end finishes the track; address stays put.
                            state_nxt = S_END;
                        end
                    end else if (back_ok) begin
                        endereco_nxt   = back_diff[ADDR_W-1:0];
                        time_adder_nxt = sat_add(time_adder, seek_dt);
                    end
                end else if (count) begin
                    zero_upd = 1'b1;
                    if (endereco == track_end) begin
                        state_nxt = S_END;
                    end else begin
                        // A zero run still advances the address on its final strobe.
                        endereco_nxt = endereco + ADDR_W'(1);
                        if (zero_hit) begin
                            state_nxt = S_END;
                        end
                    end
                end
            end
            S_END: begin
                state_nxt = S_WAIT_LOAD;
            end
            default: begin
                state_nxt = S_WAIT_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_WAIT_LOAD;
            endereco    <= '0;
            time_adder  <= '0;
            btn_prev    <= '0;
            prox_musica <= 1'b0;
            playing     <= 1'b0;
        end else begin
            state       <= state_nxt;
            endereco    <= endereco_nxt;
            time_adder  <= time_adder_nxt;
            btn_prev    <= btn_now;
            prox_musica <= (state_nxt == S_END);
            playing     <= (state_nxt == S_PLAY);
        end
    end

endmodule

// File: tb/tb_endereco_playback_seq.sv
// tb_endereco_playback_seq: directed scenarios plus randomized traffic against a behavioural model.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: not applicable.
module tb_endereco_playback_seq;

    localparam int ADDR_W = 22;
    localparam int SAMPLE_W = 8;
    localparam int TIME_W = 9;
    localparam int SPS = 4;
    localparam int ZRUN = 3;
`ifdef EOT_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     count, passa_10s, volta_10s, passa_30s, volta_30s, load;
    logic [ADDR_W-1:0]        track_start, track_end;
    logic [SAMPLE_W-1:0]      current_value;
    logic [ADDR_W-1:0]        endereco;
    logic signed [TIME_W-1:0] time_adder;
    logic                     prox_musica, playing;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: mode 0 = waiting for load, 1 = playing, 2 = end pulse cycle.
    int       m_mode, m_addr, m_ta, m_zeros;
    bit [3:0] m_prev;

    endereco_playback_seq #(
        .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .SAMPLES_PER_SEC(SPS),
        .SKIP_SHORT_S(10), .SKIP_LONG_S(30), .TIME_W(TIME_W), .ZERO_RUN(ZRUN)
    ) dut (
        .clk(clk), .reset(reset), .count(count),
        .passa_10s(passa_10s), .volta_10s(volta_10s),
        .passa_30s(passa_30s), .volta_30s(volta_30s),
        .load(load), .track_start(track_start), .track_end(track_end),
        .current_value(current_value), .endereco(endereco),
        .time_adder(time_adder), .prox_musica(prox_musica), .playing(playing)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_ta = 0; m_zeros = 0; m_prev = '0;
    endtask

    task automatic model_step();
        bit [3:0] now, edg;
        int s, step;
        bit fwd;
        now = {passa_30s, volta_30s, passa_10s, volta_10s};
        edg = now & ~m_prev;
        m_prev = now;
        if (m_mode == 2) begin
            m_mode = 0;
        end else if (load) begin
            m_addr = int'(track_start); m_ta = 0; m_zeros = 0; m_mode = 1;
        end else if (m_mode == 1 && edg != 0) begin
            s    = (edg[3] || edg[2]) ? 30 : 10;
            fwd  = edg[3] || (!edg[2] && edg[1]);
            step = s * SPS;
            if (fwd) begin
                if (m_addr + step <= int'(track_end)) begin
                    m_addr += step;
                    m_ta = (m_ta + s > 255) ? 255 : m_ta + s;
                end else begin
                    m_mode = 2;
                end
            end else if (m_addr - int'(track_start) >= step) begin
                m_addr -= step;
                m_ta = (m_ta - s < -256) ? -256 : m_ta - s;
            end
        end else if (m_mode == 1 && count) begin
            if (m_addr == int'(track_end)) m_mode = 2;
            else m_addr += 1;
            if (ZD) begin
                if (current_value == 0) begin
                    m_zeros += 1;
                    if (m_zeros == ZRUN) m_mode = 2;
                end else begin
                    m_zeros = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        count = 0; passa_10s = 0; volta_10s = 0; passa_30s = 0; volta_30s = 0; load = 0;
        track_start = 100; track_end = 400; current_value = 8'h11;
        reset = 1'b1;
        #12;
        if (endereco !== '0) begin $display("FAIL reset_addr got %0d want 0", endereco); end else n_pass++;
        n_total++;
        if (time_adder !== '0) begin $display("FAIL reset_time got %0d want 0", time_adder); end else n_pass++;
        n_total++;
        if (prox_musica !== 1'b0 || playing !== 1'b0) begin
            $display("FAIL reset_flags got prox=%b play=%b want 0 0", prox_musica, playing);
        end else n_pass++;
        n_total++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        count = 1;
        repeat (4) tick();
        count = 0;
        if (endereco !== '0 || playing !== 1'b0) begin
            $display("FAIL wait_ignores_count got addr=%0d play=%b want 0 0", endereco, playing);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_load();
        load = 1; tick(); load = 0;
        if (endereco !== 22'd100) begin $display("FAIL load_addr got %0d want 100", endereco); end else n_pass++;
        n_total++;
        if (playing !== 1'b1 || prox_musica !== 1'b0 || time_adder !== '0) begin
            $display("FAIL load_flags got play=%b prox=%b time=%0d want 1 0 0", playing, prox_musica, time_adder);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_forward_seek();
        count = 1; repeat (20) tick(); count = 0;
        if (endereco !== 22'd120) begin $display("FAIL count20_addr got %0d want 120", endereco); end else n_pass++;
        n_total++;
        passa_10s = 1; tick();
        if (endereco !== 22'd160 || time_adder !== 9'sd10) begin
            $display("FAIL fwd10 got addr=%0d time=%0d want 160 10", endereco, time_adder);
        end else n_pass++;
        n_total++;
        repeat (4) tick();
        passa_10s = 0; tick();
        if (endereco !== 22'd160 || time_adder !== 9'sd10) begin
            $display("FAIL fwd10_held got addr=%0d time=%0d want 160 10", endereco, time_adder);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_backward_seek();
        volta_30s = 1; tick(); volta_30s = 0; tick();
        if (endereco !== 22'd160 || time_adder !== 9'sd10) begin
            $display("FAIL back30_reject got addr=%0d time=%0d want 160 10", endereco, time_adder);
        end else n_pass++;
        n_total++;
        volta_10s = 1; tick(); volta_10s = 0;
        if (endereco !== 22'd120 || time_adder !== 9'sd0) begin
            $display("FAIL back10 got addr=%0d time=%0d want 120 0", endereco, time_adder);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_seek_past_end();
        count = 1; repeat (180) tick(); count = 0;
        if (endereco !== 22'd300) begin $display("FAIL reach300 got %0d want 300", endereco); end else n_pass++;
        n_total++;
        passa_30s = 1; tick(); passa_30s = 0;
        if (prox_musica !== 1'b1 || endereco !== 22'd300 || playing !== 1'b0) begin
            $display("FAIL past_end_pulse got prox=%b addr=%0d play=%b want 1 300 0", prox_musica, endereco, playing);
        end else n_pass++;
        n_total++;
        load = 1; tick(); load = 0;
        if (prox_musica !== 1'b0 || playing !== 1'b0 || endereco !== 22'd300) begin
            $display("FAIL end_ignores_load got prox=%b play=%b addr=%0d want 0 0 300", prox_musica, playing, endereco);
        end else n_pass++;
        n_total++;
        load = 1; tick(); load = 0;
        if (endereco !== 22'd100 || playing !== 1'b1) begin
            $display("FAIL reload got addr=%0d play=%b want 100 1", endereco, playing);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_zero_run();
        current_value = 0; count = 1; repeat (3) tick(); count = 0; current_value = 8'h55;
        if (endereco !== 22'd103) begin $display("FAIL zero_run_addr got %0d want 103", endereco); end else n_pass++;
        n_total++;
        if (prox_musica !== ZD || playing !== !ZD) begin
            $display("FAIL zero_run_end got prox=%b play=%b want %b %b", prox_musica, playing, ZD, !ZD);
        end else n_pass++;
        n_total++;
        tick();
        if (prox_musica !== 1'b0) begin $display("FAIL zero_run_pulse_width got %b want 0", prox_musica); end else n_pass++;
        n_total++;
    endtask

    task automatic test_saturation();
        pulse_reset();
        track_start = 0; track_end = 4000;
        load = 1; tick(); load = 0;
        repeat (10) begin
            passa_30s = 1; tick(); passa_30s = 0; tick();
        end
        if (endereco !== 22'd1200 || time_adder !== 9'sd255) begin
            $display("FAIL time_sat_hi got addr=%0d time=%0d want 1200 255", endereco, time_adder);
        end else n_pass++;
        n_total++;
        volta_30s = 1; tick(); volta_30s = 0;
        if (endereco !== 22'd1080 || time_adder !== 9'sd225) begin
            $display("FAIL time_after_sat got addr=%0d time=%0d want 1080 225", endereco, time_adder);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid_play();
        pulse_reset();
        track_start = 100; track_end = 400;
        load = 1; tick(); load = 0;
        passa_30s = 1; tick(); passa_30s = 0;
        count = 1; repeat (30) tick();
        if (endereco !== 22'd250) begin $display("FAIL reach250 got %0d want 250", endereco); end else n_pass++;
        n_total++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        if (endereco !== '0 || time_adder !== '0 || playing !== 1'b0) begin
            $display("FAIL async_reset got addr=%0d time=%0d play=%b want 0 0 0", endereco, time_adder, playing);
        end else n_pass++;
        n_total++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (5) tick();
        count = 0;
        if (endereco !== '0 || playing !== 1'b0) begin
            $display("FAIL post_reset_count got addr=%0d play=%b want 0 0", endereco, playing);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_random();
        int ts;
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == 0 && $urandom_range(0, 3) == 0) begin
                ts = $urandom_range(0, 200);
                track_start = ADDR_W'(ts);
                track_end   = ADDR_W'(ts + $urandom_range(50, 600));
            end
            load          = ($urandom_range(0, 39) == 0);
            passa_30s     = ($urandom_range(0, 5) == 0);
            volta_30s     = ($urandom_range(0, 5) == 0);
            passa_10s     = ($urandom_range(0, 5) == 0);
            volta_10s     = ($urandom_range(0, 5) == 0);
            count         = ($urandom_range(0, 1) == 1);
            current_value = ($urandom_range(0, 1) == 1) ? 8'd0 : SAMPLE_W'($urandom_range(1, 255));
            tick();
            if (int'(endereco) !== m_addr || int'(time_adder) !== m_ta ||
                prox_musica !== (m_mode == 2) || playing !== (m_mode == 1)) begin
                $display("FAIL random_cycle%0d got addr=%0d time=%0d prox=%b play=%b want %0d %0d %b %b",
                         i, endereco, time_adder, prox_musica, playing,
                         m_addr, m_ta, (m_mode == 2), (m_mode == 1));
            end else n_pass++;
            n_total++;
        end
        load = 0; count = 0; passa_30s = 0; volta_30s = 0; passa_10s = 0; volta_10s = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_forward_seek();
        test_backward_seek();
        test_seek_past_end();
        test_zero_run();
        test_saturation();
        test_reset_mid_play();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
